pipe_skid_stage: RTL and testbench
==================================

Name: pipe_skid_stage

Overview:
- Parametrised, handshaked pipeline-boundary register; the successor to the fixed-field E2M/M2W stage registers.
- Carries a data bundle, a control bundle and a destination-register index between two pipeline stages.
- Uses valid/ready flow control with a 2-entry skid buffer, so that in_ready is registered and throughput stays at 1 transfer/cycle.
- Supports synchronous flush, which inserts bubbles for branch/jump squash.

Parameters:
- DATA_W, 32: width of one data word.
- N_DATA, 5: number of data words carried (ALU result, write data, PC+4, PC target, imm).
- CTRL_W, 8: control bundle width (RegWrite, MemWrite, ResultSrc, Byte_Half_Op, sign, ...).
- RD_W, 5: destination register index width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  upstream has a bundle.
- in_ready  out  1  stage can accept (registered).
- in_data  in  N_DATA*DATA_W  data words, word k at bits [k*DATA_W +: DATA_W].
- in_ctrl  in  CTRL_W  control bundle.
- in_rd  in  RD_W  destination register.
- out_valid  out  1  bundle presented downstream.
- out_ready  in  1  downstream accepts.
- out_data  out  N_DATA*DATA_W  data words.
- out_ctrl  out  CTRL_W  control; forced 0 when out_valid=0.
- out_rd  out  RD_W  destination; forced 0 when out_valid=0.
- occupancy  out  2  entries held (0..2).

Behaviour:
- Storage: main entry (drives outputs) and skid entry; each holds data, ctrl, rd and a valid bit.
- Transfers: accept = in_valid & in_ready; drain = out_valid & out_ready.
- States:
  - EMPTY: main and skid invalid. in_ready=1.
  - ONE: main valid, skid invalid. in_ready=1.
  - FULL: main and skid valid. in_ready=0.
- Transitions (no flush):
  - EMPTY + accept -> ONE; bundle is loaded into main.
  - ONE + accept & drain -> ONE; main is reloaded with the new bundle (pass-through, 1 transfer/cycle).
  - ONE + accept & !drain -> FULL; bundle goes to skid.
  - ONE + drain & !accept -> EMPTY.
  - FULL + drain -> ONE; skid moves to main. No accept is possible in FULL because in_ready=0.
  - Any other combination: hold.
- Latency: 1 cycle from accept to out_valid when the stage is EMPTY or draining.
- in_ready is a flop equal to !skid_valid. There is no combinational in->out path except the ctrl/rd zeroing gate.
- Ordering: strictly FIFO. A bundle accepted while the stage is FULL is impossible. A skid entry always precedes any newer bundle.
- Data registers load only on accept or skid->main move. A flush or drain does not clear them; out_data is don't-care when out_valid=0.
- flush:
  - Highest priority.
  - At the next edge, main and skid valid bits clear (state -> EMPTY) and in_ready becomes 1.
  - A bundle offered with in_valid in the flush cycle is discarded, even if in_ready=1.
  - A drain in the flush cycle still counts as consumed downstream.
- Bubble: whenever out_valid=0, out_ctrl=0 and out_rd=0, so a bubble never writes the register file or memory.
- Reset (RST=1, async): all valid bits 0, in_ready=0 while RST is asserted, in_ready=1 on the first edge after release. out_valid=0, out_ctrl=0, out_rd=0, out_data=0, occupancy=0.
- Reset asserted mid-transfer: all held bundles are lost. There is no partial output.
- occupancy = main_valid + skid_valid.

Optional Feature:
- Macro: PIPE_SKID_PERF_EN.
- Defined: adds outputs stall_cnt[31:0] and bubble_cnt[31:0].
  - stall_cnt increments each cycle with in_valid & !in_ready.
  - bubble_cnt increments each cycle with out_ready & !out_valid.
  - Both wrap at 2^32 without saturating, clear on RST, and are unaffected by flush.
- Undefined: the ports and counters do not exist. Behaviour is otherwise identical.

Test Plan:
- Reset release with in_valid=1 continuously and out_ready=1; in_data word0 = 0x1, 0x2, 0x3, ... -> out_valid rises 1 cycle after the first accept; out_data word0 sequence 1, 2, 3 with no gaps; occupancy stays 1.
- Back-pressure: stream 0xA0..0xA3, out_ready=0 for 2 cycles -> occupancy reaches 2, in_ready=0, no loss or duplication; release shows 0xA0, 0xA1, 0xA2, 0xA3 in order.
- Flush while FULL with in_valid=1 (in_data 0xDEAD) -> next cycle out_valid=0, out_ctrl=0, out_rd=0, occupancy=0, in_ready=1; 0xDEAD never appears at the output.
- Bubble gating: accept ctrl=0xFF, rd=5, then idle with out_ready=1 -> out_ctrl=0xFF, out_rd=5 for one cycle, then both 0.
- Async RST pulse between clock edges while FULL -> outputs zero immediately without waiting for CLK; after release, first accepted bundle emerges correctly.
- With PIPE_SKID_PERF_EN defined: hold out_ready=0, in_valid=1 for 10 cycles from EMPTY -> stall_cnt=8 (2 accepts fill the stage); out_ready=1, in_valid=0 for 4 cycles after draining -> bubble_cnt increments 1 per empty cycle.

Source files
------------

// File: rtl/pipe_skid_stage.sv
// Handshaked pipeline-boundary register with a 2-entry skid buffer and synchronous flush.
// Define PIPE_SKID_PERF_EN to add the stall_cnt / bubble_cnt performance counters.
module pipe_skid_stage #(
    parameter int DATA_W = 32,
    parameter int N_DATA = 5,
    parameter int CTRL_W = 8,
    parameter int RD_W   = 5
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_DATA*DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0]        in_ctrl,
    input  logic [RD_W-1:0]          in_rd,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_DATA*DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0]        out_ctrl,
    output logic [RD_W-1:0]          out_rd,
`ifdef PIPE_SKID_PERF_EN
    output logic [31:0]              stall_cnt,
    output logic [31:0]              bubble_cnt,
`endif
    output logic [1:0]               occupancy
);

    // Handshake: a bundle moves across a port on a rising edge when valid and ready
    // are both high in the preceding cycle; valid never depends on ready.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                    state;
    logic                      rdy_q;
    logic [N_DATA*DATA_W-1:0]  main_data;
    logic [CTRL_W-1:0]         main_ctrl;
    logic [RD_W-1:0]           main_rd;
    logic [N_DATA*DATA_W-1:0]  skid_data;
    logic [CTRL_W-1:0]         skid_ctrl;
    logic [RD_W-1:0]           skid_rd;

    logic accept;
    logic drain;
    logic main_valid;
    logic skid_valid;

    assign main_valid = (state != EMPTY);
    assign skid_valid = (state == FULL);
    assign accept     = in_valid & rdy_q;
    assign drain      = main_valid & out_ready;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= EMPTY;
            rdy_q     <= 1'b0;
            main_data <= '0;
            main_ctrl <= '0;
            main_rd   <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
            skid_rd   <= '0;
        end else if (flush) begin
            // Squash drops valid bits only; any offered bundle is discarded.
            state <= EMPTY;
            rdy_q <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    rdy_q <= 1'b1;
                    if (accept) begin
                        main_data <= in_data;
                        main_ctrl <= in_ctrl;
                        main_rd   <= in_rd;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        main_data <= in_data;
                        main_ctrl <= in_ctrl;
                        main_rd   <= in_rd;
                        rdy_q     <= 1'b1;
                    end else if (accept) begin
                        skid_data <= in_data;
                        skid_ctrl <= in_ctrl;
                        skid_rd   <= in_rd;
                        state     <= FULL;
                        rdy_q     <= 1'b0;
                    end else if (drain) begin
                        state <= EMPTY;
                        rdy_q <= 1'b1;
                    end else begin
                        rdy_q <= 1'b1;
                    end
                end
                FULL: begin
                    // in_ready is low here, so the only legal move is skid -> main.
                    if (drain) begin
                        main_data <= skid_data;
                        main_ctrl <= skid_ctrl;
                        main_rd   <= skid_rd;
                        state     <= ONE;
                        rdy_q     <= 1'b1;
                    end else begin
                        rdy_q <= 1'b0;
                    end
                end
                default: begin
                    state <= EMPTY;
                    rdy_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    // Bubbles must never write the register file or memory.
    assign out_ctrl  = main_valid ? main_ctrl : '0;
    assign out_rd    = main_valid ? main_rd : '0;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

`ifdef PIPE_SKID_PERF_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (in_valid && !rdy_q) stall_cnt <= stall_cnt + 32'd1;
            if (out_ready && !main_valid) bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: queue scoreboard of accepted bundles checked on drain.
// Also exercises the counters when PIPE_SKID_PERF_EN is defined.
module tb_pipe_skid_stage;

    localparam int DATA_W = 32;
    localparam int N_DATA = 5;
    localparam int CTRL_W = 8;
    localparam int RD_W   = 5;
    localparam int DW     = N_DATA * DATA_W;
    localparam int W      = DW + CTRL_W + RD_W;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic [RD_W-1:0]   in_rd = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [RD_W-1:0]   out_rd;
    logic [1:0]    occupancy;
`ifdef PIPE_SKID_PERF_EN
    logic [31:0]   stall_cnt;
    logic [31:0]   bubble_cnt;
`endif

    int checks = 0;
    int errors = 0;
    bit rst_fresh = 1'b0;
    logic [W-1:0] exp_q[$];

    pipe_skid_stage #(
        .DATA_W(DATA_W), .N_DATA(N_DATA), .CTRL_W(CTRL_W), .RD_W(RD_W)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_ctrl(in_ctrl),
        .in_rd(in_rd),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_ctrl(out_ctrl),
        .out_rd(out_rd),
`ifdef PIPE_SKID_PERF_EN
        .stall_cnt(stall_cnt),
        .bubble_cnt(bubble_cnt),
`endif
        .occupancy(occupancy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mkdata(input logic [31:0] s);
        logic [DW-1:0] d;
        d = '0;
        for (int k = 0; k < N_DATA; k++) d[k*DATA_W +: DATA_W] = s + (32'(k) << 16);
        return d;
    endfunction

    // Called at a falling edge with inputs already set; samples 1 unit before the rising edge.
    task automatic tick(output bit acc);
        bit drn;
        logic [W-1:0] e;
        #4;
        acc = in_valid && in_ready;
        drn = out_valid && out_ready;
        chk("in_ready", W'(in_ready), rst_fresh ? W'(0) : W'(exp_q.size() < 2));
        chk("occupancy", W'(occupancy), W'(exp_q.size()));
        chk("out_valid", W'(out_valid), W'(exp_q.size() != 0));
        if (exp_q.size() == 0) chk("bubble_ctrl_rd", W'({out_rd, out_ctrl}), W'(0));
        if (drn && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("out_bundle", {out_rd, out_ctrl, out_data}, e);
        end
        if (flush) exp_q.delete();
        else if (acc) exp_q.push_back({in_rd, in_ctrl, in_data});
        rst_fresh = 1'b0;
        @(negedge CLK);
    endtask

    // Offers n bundles from base, out_ready low for the first ready_after cycles, then drains.
    task automatic run(input logic [31:0] base, input int n, input int ready_after, input int max_cyc);
        int idx;
        bit a;
        idx = 0;
        for (int c = 0; c < max_cyc && (idx < n || exp_q.size() > 0); c++) begin
            in_valid  = (idx < n);
            in_data   = mkdata(base + 32'(idx));
            in_ctrl   = CTRL_W'(base + 32'(idx) * 3);
            in_rd     = RD_W'(base + 32'(idx));
            out_ready = (c >= ready_after);
            tick(a);
            if (a) idx++;
        end
        in_valid = 1'b0;
        chk("stream_done", W'(idx == n && exp_q.size() == 0), W'(1));
    endtask

    initial begin
        bit a;
`ifdef PIPE_SKID_PERF_EN
        logic [31:0] s0, b0;
`endif
        // Reset state
        @(negedge CLK);
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_in_ready", W'(in_ready), W'(0));
        chk("rst_occupancy", W'(occupancy), W'(0));
        chk("rst_out_ctrl_rd", W'({out_rd, out_ctrl}), W'(0));
        chk("rst_out_data", W'(out_data), W'(0));
        @(negedge CLK);
        RST = 1'b0;
        rst_fresh = 1'b1;

        // Continuous streaming straight out of reset
        run(32'h1, 8, 0, 40);

        // Back-pressure fills the skid entry
        run(32'hA0, 4, 3, 40);

        // Flush while FULL with a bundle offered
        in_valid = 1'b1; out_ready = 1'b0;
        in_data = mkdata(32'h10); in_ctrl = 8'h11; in_rd = 5'd1; tick(a);
        in_data = mkdata(32'h11); in_ctrl = 8'h12; in_rd = 5'd2; tick(a);
        chk("pre_flush_occ", W'(occupancy), W'(2));
        in_data = mkdata(32'hDEAD); in_ctrl = 8'hAD; in_rd = 5'd13; flush = 1'b1;
        tick(a);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick(a);

        // Bubble gating of ctrl/rd after a single bundle
        in_valid = 1'b1; in_data = mkdata(32'h55); in_ctrl = 8'hFF; in_rd = 5'd5;
        tick(a);
        in_valid = 1'b0;
        #4;
        chk("gate_ctrl_valid", W'(out_ctrl), W'(8'hFF));
        chk("gate_rd_valid", W'(out_rd), W'(5));
        @(negedge CLK);
        exp_q.delete();
        #4;
        chk("gate_ctrl_bubble", W'(out_ctrl), W'(0));
        chk("gate_rd_bubble", W'(out_rd), W'(0));
        @(negedge CLK);

        // Asynchronous reset pulse while FULL
        in_valid = 1'b1; out_ready = 1'b0;
        in_data = mkdata(32'h200); in_ctrl = 8'h21; in_rd = 5'd3; tick(a);
        in_data = mkdata(32'h201); in_ctrl = 8'h22; in_rd = 5'd4; tick(a);
        in_valid = 1'b0;
        chk("pre_rst_occ", W'(occupancy), W'(2));
        #2 RST = 1'b1;
        #1;
        chk("arst_out_valid", W'(out_valid), W'(0));
        chk("arst_occupancy", W'(occupancy), W'(0));
        chk("arst_ctrl_rd", W'({out_rd, out_ctrl}), W'(0));
        chk("arst_data", W'(out_data), W'(0));
        chk("arst_in_ready", W'(in_ready), W'(0));
        @(negedge CLK);
        RST = 1'b0;
        exp_q.delete();
        rst_fresh = 1'b1;
        run(32'h300, 3, 0, 20);

`ifdef PIPE_SKID_PERF_EN
        s0 = stall_cnt;
        in_valid = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_data = mkdata(32'h400 + 32'(i)); in_ctrl = 8'(i); in_rd = 5'(i);
            tick(a);
        end
        in_valid = 1'b0;
        chk("stall_cnt_delta", W'(stall_cnt - s0), W'(8));
        out_ready = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick(a);
        chk("perf_drained", W'(exp_q.size()), W'(0));
        b0 = bubble_cnt;
        for (int i = 0; i < 4; i++) tick(a);
        chk("bubble_cnt_delta", W'(bubble_cnt - b0), W'(4));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
